// File: rtl/mem_pkg.sv
// Shared encodings and sizes for the byte-wide memory access controller.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 12;
    localparam int unsigned MEM_BYTES  = 4096;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        XFER  = 2'b01,
        DRAIN = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Request fields held for the duration of one transaction.
    typedef struct packed {
        logic                  we;
        size_e                 size;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } req_t;

    // Index of the last byte lane touched by a request of the given size.
    function automatic logic [1:0] last_idx(input size_e size);
        case (size)
            SZ_HALF: last_idx = 2'd1;
            SZ_WORD: last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_word_ctrl_if.sv
// Request/response handshake bundle between the core side and the controller.
interface mem_word_ctrl_if;
    import mem_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    size_e                 req_size;
    logic [MEM_ADDR_W-1:0] req_addr;
    logic [MEM_DATA_W-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [MEM_DATA_W-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_word_ctrl.sv
// Serialises byte/half/word requests into little-endian byte accesses on a
// 1-cycle registered-read byte memory and returns one response per request.
module mem_word_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    mem_word_ctrl_if.slave    bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_in,
    input  logic [7:0]        mem_out
);

    state_e              r_state, w_state_nxt;
    logic [1:0]          r_cnt, w_cnt_nxt;
    req_t                r_req, w_req_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_err, w_err_nxt;
    logic                r_resp_valid, w_resp_valid_nxt;
    logic [1:0]          w_last;
    logic [1:0]          w_prev;

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_req        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req        <= w_req_nxt;
            r_rdata      <= w_rdata_nxt;
            r_err        <= w_err_nxt;
            r_resp_valid <= w_resp_valid_nxt;
        end
    end

    // Next-state, byte-lane sequencing and memory port drive.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_req_nxt        = r_req;
        w_rdata_nxt      = r_rdata;
        w_err_nxt        = r_err;
        w_resp_valid_nxt = r_resp_valid;
        w_last           = last_idx(r_req.size);
        w_prev           = r_cnt - 2'd1;
        mem_we           = 1'b0;
        mem_in           = 8'h00;
        // Base + lane offset wraps naturally at the top of the address space.
        mem_addr         = ADDR_W'(r_req.addr + MEM_ADDR_W'(r_cnt));

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_req_nxt.we    = bus.req_we;
                    w_req_nxt.size  = bus.req_size;
                    w_req_nxt.addr  = bus.req_addr;
                    w_req_nxt.wdata = bus.req_wdata;
                    w_rdata_nxt     = '0;
                    w_cnt_nxt       = 2'd0;
                    if (bus.req_size == SZ_RSVD) begin
                        w_err_nxt        = 1'b1;
                        w_resp_valid_nxt = 1'b1;
                        w_state_nxt      = RESP;
                    end else begin
                        w_err_nxt   = 1'b0;
                        w_state_nxt = XFER;
                    end
                end
            end
            XFER: begin
                mem_we = r_req.we;
                if (r_req.we) begin
                    mem_in = r_req.wdata[{r_cnt, 3'b000} +: 8];
                end else if (r_cnt != 2'd0) begin
                    // Read data for the previous lane's address arrives now.
                    w_rdata_nxt[{w_prev, 3'b000} +: 8] = mem_out;
                end
                if (r_cnt == w_last) begin
                    if (r_req.we) begin
                        w_resp_valid_nxt = 1'b1;
                        w_state_nxt      = RESP;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            DRAIN: begin
                w_rdata_nxt[{w_last, 3'b000} +: 8] = mem_out;
                w_resp_valid_nxt                   = 1'b1;
                w_state_nxt                        = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Directed bench for mem_word_ctrl with a behavioural 4 KiB byte memory.
module tb_mem_word_ctrl;
    import mem_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [7:0]            mem_in;
    logic [7:0]            mem_out;
    logic [7:0]            mem [MEM_BYTES];

    int n_assert;
    int n_fail;
    int we_cnt;
    int lat;
    int we_base;
    int vcnt;

    mem_word_ctrl_if bus ();

    mem_word_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory with a one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_in;
        mem_out <= mem[mem_addr];
    end

    // Counts every cycle on which a write strobe reaches the memory.
    initial we_cnt = 0;
    always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, confirm it is accepted on the next edge, then drop it.
    task automatic start(input logic we, input size_e size, input logic [11:0] addr,
                         input logic [31:0] wdata, input string tag);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Edges after the accept edge until resp_valid is seen (bounded).
    task automatic wait_resp(output int cycles);
        cycles = 0;
        while (!bus.resp_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic handshake(input string tag);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_BYTE;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ready",    32'(bus.req_ready),  32'd1);
        chk("rst_rvalid",   32'(bus.resp_valid), 32'd0);
        chk("rst_rdata",    bus.resp_rdata,      32'd0);
        chk("rst_err",      32'(bus.resp_err),   32'd0);
        chk("rst_mem_we",   32'(mem_we),         32'd0);
        chk("rst_mem_addr", 32'(mem_addr),       32'd0);
        chk("rst_mem_in",   32'(mem_in),         32'd0);

        // 1. Word write then word read at 0x010
        start(1'b1, SZ_WORD, 12'h010, 32'hDDCCBBAA, "w1");
        wait_resp(lat);
        chk("w1_lat",   32'(lat),          32'd4);
        chk("w1_err",   32'(bus.resp_err), 32'd0);
        chk("w1_rdata", bus.resp_rdata,    32'd0);
        handshake("w1");
        chk("w1_m010", 32'(mem[12'h010]), 32'hAA);
        chk("w1_m011", 32'(mem[12'h011]), 32'hBB);
        chk("w1_m012", 32'(mem[12'h012]), 32'hCC);
        chk("w1_m013", 32'(mem[12'h013]), 32'hDD);
        start(1'b0, SZ_WORD, 12'h010, 32'h0, "r1");
        wait_resp(lat);
        chk("r1_lat",   32'(lat),       32'd5);
        chk("r1_rdata", bus.resp_rdata, 32'hDDCCBBAA);
        handshake("r1");

        // 2. Half write across 0x7FF/0x800, byte and half reads
        start(1'b1, SZ_HALF, 12'h7FF, 32'h00001234, "w2");
        wait_resp(lat);
        chk("w2_lat", 32'(lat), 32'd2);
        handshake("w2");
        start(1'b0, SZ_BYTE, 12'h7FF, 32'h0, "r2a");
        wait_resp(lat);
        chk("r2a_lat",   32'(lat),       32'd2);
        chk("r2a_rdata", bus.resp_rdata, 32'h00000034);
        handshake("r2a");
        start(1'b0, SZ_BYTE, 12'h800, 32'h0, "r2b");
        wait_resp(lat);
        chk("r2b_rdata", bus.resp_rdata, 32'h00000012);
        handshake("r2b");
        start(1'b0, SZ_HALF, 12'h7FF, 32'h0, "r2c");
        wait_resp(lat);
        chk("r2c_lat",   32'(lat),       32'd3);
        chk("r2c_rdata", bus.resp_rdata, 32'h00001234);
        handshake("r2c");

        // 3. Address wrap at the top of memory
        start(1'b1, SZ_WORD, 12'hFFE, 32'h44332211, "w3");
        wait_resp(lat);
        chk("w3_lat", 32'(lat), 32'd4);
        handshake("w3");
        chk("w3_mFFE", 32'(mem[12'hFFE]), 32'h11);
        chk("w3_mFFF", 32'(mem[12'hFFF]), 32'h22);
        chk("w3_m000", 32'(mem[12'h000]), 32'h33);
        chk("w3_m001", 32'(mem[12'h001]), 32'h44);
        start(1'b0, SZ_WORD, 12'hFFE, 32'h0, "r3");
        wait_resp(lat);
        chk("r3_rdata", bus.resp_rdata, 32'h44332211);
        handshake("r3");

        // 4. Reserved size: immediate error, no memory write
        we_base = we_cnt;
        start(1'b0, SZ_RSVD, 12'h100, 32'hFFFFFFFF, "e4");
        chk("e4_valid", 32'(bus.resp_valid), 32'd1);
        chk("e4_err",   32'(bus.resp_err),   32'd1);
        chk("e4_rdata", bus.resp_rdata,      32'd0);
        handshake("e4");
        chk("e4_no_we", 32'(we_cnt - we_base), 32'd0);

        // 5. Response backpressure with a second request waiting
        start(1'b0, SZ_WORD, 12'hFFE, 32'h0, "b5");
        wait_resp(lat);
        chk("b5_lat", 32'(lat), 32'd5);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = 12'h010;
        for (int i = 0; i < 5; i++) begin
            chk("b5_hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("b5_hold_rdata", bus.resp_rdata,      32'h44332211);
            chk("b5_hold_ready", 32'(bus.req_ready),  32'd0);
            tick();
        end
        handshake("b5");
        chk("b5_post_hs_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("b5_second_accepted", 32'(bus.req_ready), 32'd0);
        wait_resp(lat);
        chk("b5_second_lat",   32'(lat),       32'd2);
        chk("b5_second_rdata", bus.resp_rdata, 32'h000000AA);
        handshake("b5b");

        // 6. Reset during a word write after two bytes
        start(1'b1, SZ_WORD, 12'h010, 32'h55667788, "x6");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("x6_mem_we", 32'(mem_we),          32'd0);
        chk("x6_rvalid", 32'(bus.resp_valid),  32'd0);
        chk("x6_ready",  32'(bus.req_ready),   32'd1);
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.resp_valid) vcnt++;
        end
        chk("x6_no_resp", 32'(vcnt), 32'd0);
        chk("x6_m010", 32'(mem[12'h010]), 32'h88);
        chk("x6_m011", 32'(mem[12'h011]), 32'h77);
        chk("x6_m012", 32'(mem[12'h012]), 32'hCC);
        chk("x6_m013", 32'(mem[12'h013]), 32'hDD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
